spike_rate_decoder: RTL and testbench

- Decodes the 2-bit output spike vector from the excitatory layer (bit0 = Left, bit1 = Right) into per-window firing rates and a steering command for the motor controller.
- It is the inverse of the input neurons, which encode sensor values into spike trains.
- It counts spikes over a fixed window of enabled cycles, snapshots the result, and presents it through a valid/ready handshake.

---
 rtl/snn_decoder_pkg.sv | 17 +
 rtl/spike_counter.sv | 31 +++
 rtl/spike_rate_decoder.sv | 96 +++++++++
 tb/tb_spike_rate_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snn_decoder_pkg.sv
// Shared encodings for the spike-rate decoder: steering directions,
// output-FSM states and channel indices into the spike vector.
package snn_decoder_pkg;

   localparam logic [1:0] DIR_NONE  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;

   typedef enum logic {
      EMPTY   = 1'b0,
      PENDING = 1'b1
   } out_state_t;

   localparam int CH_LEFT  = 0;
   localparam int CH_RIGHT = 1;

endpackage

// File: rtl/spike_counter.sv
// Saturating per-channel spike accumulator. The snapshot already includes
// the current sample so the window-end spike lands in the ending window.
module spike_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike,
   input  logic             clear_on_end,
   output logic [CNT_W-1:0] snapshot
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] acc;

   always_comb begin
      snapshot = (acc == CNT_MAX) ? acc : acc + CNT_W'(spike);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         if (clear_on_end) acc <= '0;
         else              acc <= snapshot;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts Left/Right spikes over a window of enabled cycles and presents the
// rates plus a steering command to the motor controller via valid/ready.
module spike_rate_decoder
   import snn_decoder_pkg::*;
#(
   parameter int WINDOW = 100,
   parameter int WIN_W  = 8,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       spike_in,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [CNT_W-1:0] rate_left,
   output logic [CNT_W-1:0] rate_right,
   output logic [CNT_W:0]   steer,
   output logic [1:0]       dir,
   output logic             overrun
);

   logic [WIN_W-1:0] win_cnt;
   logic             window_end;
   logic [CNT_W-1:0] snap [2];
   logic [CNT_W:0]   steer_next;
   logic [1:0]       dir_next;
   out_state_t       state, state_next;

   assign window_end = en && (win_cnt == WIN_W'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (rst)             win_cnt <= '0;
      else if (window_end) win_cnt <= '0;
      else if (en)         win_cnt <= win_cnt + 1'b1;
   end

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk          (clk),
         .rst          (rst),
         .en           (en),
         .spike        (spike_in[ch]),
         .clear_on_end (window_end),
         .snapshot     (snap[ch])
      );
   end

   // Zero-extending both rates first keeps the difference overflow-free.
   always_comb begin
      steer_next = {1'b0, snap[CH_LEFT]} - {1'b0, snap[CH_RIGHT]};
      if (steer_next == '0)      dir_next = DIR_NONE;
      else if (steer_next[CNT_W]) dir_next = DIR_RIGHT;
      else                       dir_next = DIR_LEFT;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (window_end) state_next = PENDING;
         PENDING: if (window_end) state_next = PENDING;
                  else if (cmd_ready) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      cmd_valid = (state == PENDING);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rate_left  <= '0;
         rate_right <= '0;
         steer      <= '0;
         dir        <= DIR_NONE;
      end else if (window_end) begin
         rate_left  <= snap[CH_LEFT];
         rate_right <= snap[CH_RIGHT];
         steer      <= steer_next;
         dir        <= dir_next;
      end
   end

   // Overrun only when an unaccepted command is replaced by a new snapshot.
   always_ff @(posedge clk) begin
      if (rst)                                              overrun <= 1'b0;
      else if (state == PENDING && window_end && !cmd_ready) overrun <= 1'b1;
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and directed bench for spike_rate_decoder: a window-level model
// pushes expected commands, a negedge monitor pops and compares them.
module tb_spike_rate_decoder;

   localparam int WINDOW = 10;

   typedef struct {
      int l;
      int r;
   } cmd_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] spike_in;
   logic       cmd_ready;

   logic              valid4, ov4;
   logic [3:0]        rl4, rr4;
   logic signed [4:0] st4;
   logic [1:0]        dir4;

   logic              valid3, ov3;
   logic [2:0]        rl3, rr3;
   logic signed [3:0] st3;
   logic [1:0]        dir3;

   int checks   = 0;
   int failures = 0;

   cmd_t q0[$];
   cmd_t q1[$];
   cmd_t last0, last1;
   bit   ov_exp0, ov_exp1;
   bit   started = 1'b0;
   int   raw_l, raw_r, win;

   always #5 clk = ~clk;

   spike_rate_decoder #(.WINDOW(WINDOW), .WIN_W(8), .CNT_W(4)) dut (
      .clk (clk), .rst (rst), .en (en), .spike_in (spike_in),
      .cmd_ready (cmd_ready), .cmd_valid (valid4), .rate_left (rl4),
      .rate_right (rr4), .steer (st4), .dir (dir4), .overrun (ov4)
   );

   spike_rate_decoder #(.WINDOW(WINDOW), .WIN_W(8), .CNT_W(3)) dut3 (
      .clk (clk), .rst (rst), .en (en), .spike_in (spike_in),
      .cmd_ready (cmd_ready), .cmd_valid (valid3), .rate_left (rl3),
      .rate_right (rr3), .steer (st3), .dir (dir3), .overrun (ov3)
   );

   function automatic int clamp(int v, int m);
      return (v > m) ? m : v;
   endfunction

   function automatic int exp_dir(cmd_t c);
      if (c.l > c.r) return 1;
      if (c.r > c.l) return 2;
      return 0;
   endfunction

   task automatic check_output(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_cmd(string tag, cmd_t c, int l, int r, int s, int d);
      check_output({tag, ".rate_left"},  l, c.l);
      check_output({tag, ".rate_right"}, r, c.r);
      check_output({tag, ".steer"},      s, c.l - c.r);
      check_output({tag, ".dir"},        d, exp_dir(c));
   endtask

   task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] s,
                                 input logic rdy);
      rst       = r;
      en        = e;
      spike_in  = s;
      cmd_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Window-level reference: raw spike totals per window, clamped per instance.
   initial forever begin
      cmd_t c0, c1;
      @(posedge clk);
      if (rst) begin
         q0.delete();
         q1.delete();
         last0   = '{0, 0};
         last1   = '{0, 0};
         ov_exp0 = 1'b0;
         ov_exp1 = 1'b0;
         raw_l   = 0;
         raw_r   = 0;
         win     = 0;
         started = 1'b1;
      end else if (en) begin
         raw_l += int'(spike_in[0]);
         raw_r += int'(spike_in[1]);
         win++;
         if (win == WINDOW) begin
            c0 = '{clamp(raw_l, 15), clamp(raw_r, 15)};
            c1 = '{clamp(raw_l, 7),  clamp(raw_r, 7)};
            if (q0.size() > 0) begin q0[0] = c0; ov_exp0 = 1'b1; end
            else q0.push_back(c0);
            if (q1.size() > 0) begin q1[0] = c1; ov_exp1 = 1'b1; end
            else q1.push_back(c1);
            last0 = c0;
            last1 = c1;
            raw_l = 0;
            raw_r = 0;
            win   = 0;
         end
      end
   end

   // Monitor: compares presented outputs, pops on an accepted transfer.
   initial forever begin
      @(negedge clk);
      if (started) begin
         check_output("w4.cmd_valid", int'(valid4), int'(q0.size() > 0));
         check_output("w4.overrun",   int'(ov4),    int'(ov_exp0));
         if (valid4 && q0.size() > 0) begin
            check_cmd("w4", q0[0], int'(rl4), int'(rr4), int'(st4), int'(dir4));
            if (cmd_ready) void'(q0.pop_front());
         end else if (!valid4) begin
            check_cmd("w4.held", last0, int'(rl4), int'(rr4), int'(st4), int'(dir4));
         end
         check_output("w3.cmd_valid", int'(valid3), int'(q1.size() > 0));
         check_output("w3.overrun",   int'(ov3),    int'(ov_exp1));
         if (valid3 && q1.size() > 0) begin
            check_cmd("w3", q1[0], int'(rl3), int'(rr3), int'(st3), int'(dir3));
            if (cmd_ready) void'(q1.pop_front());
         end else if (!valid3) begin
            check_cmd("w3.held", last1, int'(rl3), int'(rr3), int'(st3), int'(dir3));
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; spike_in = 2'b00; cmd_ready = 1'b0;
      repeat (3) apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0);

      // Left on every sample, accepted immediately.
      for (int i = 0; i < WINDOW; i++) apply_stimulus(1'b0, 1'b1, 2'b01, 1'b1);
      repeat (3) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      // 3 Left / 7 Right, ready held low for 5 cycles.
      for (int i = 0; i < WINDOW; i++)
         apply_stimulus(1'b0, 1'b1, {logic'(i < 7), logic'(i < 3)}, 1'b0);
      repeat (5) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      repeat (2) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      // Two windows without ready: 4/4 then 2/6, second overwrites first.
      for (int i = 0; i < WINDOW; i++)
         apply_stimulus(1'b0, 1'b1, {logic'(i < 4), logic'(i < 4)}, 1'b0);
      for (int i = 0; i < WINDOW; i++)
         apply_stimulus(1'b0, 1'b1, {logic'(i < 6), logic'(i < 2)}, 1'b0);
      repeat (3) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      // Window paused by en low while spikes are still driven.
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 2'($urandom_range(3)), 1'b1);
      repeat (7) apply_stimulus(1'b0, 1'b0, 2'b11, 1'b1);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 2'($urandom_range(3)), 1'b1);
      repeat (2) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      // Left every sample: saturates the 3-bit instance at 7.
      for (int i = 0; i < WINDOW; i++) apply_stimulus(1'b0, 1'b1, 2'b01, 1'b0);
      repeat (2) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      // Reset mid-window while a command is pending.
      for (int i = 0; i < WINDOW + 4; i++) apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0);
      apply_stimulus(1'b1, 1'b1, 2'b11, 1'b0);
      for (int i = 0; i < WINDOW + 2; i++) apply_stimulus(1'b0, 1'b1, 2'b01, 1'b1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         apply_stimulus(logic'($urandom_range(199) == 0), logic'($urandom_range(3) != 0),
                        2'($urandom_range(3)), logic'($urandom_range(1)));
      repeat (4) apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
